// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional 2-entry skid buffer
module pipe_stage_reg #(
    parameter int DATA_W      = 165,
    parameter bit SKID        = 1'b1,
    parameter bit BUBBLE_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              m_valid, m_valid_nx;
    logic              s_valid, s_valid_nx;
    logic [DATA_W-1:0] m_data, m_data_nx;
    logic [DATA_W-1:0] s_data, s_data_nx;
    logic [1:0]        count_q;
    logic              accept, drain;

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign count     = count_q;

    // With the skid buffer, in_ready depends only on S occupancy so it never
    // combinationally follows out_ready.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (SKID) in_ready = !s_valid;
            else      in_ready = !m_valid || out_ready;
        end
    end

    assign accept = in_valid && in_ready;
    assign drain  = m_valid && out_ready;

    always_comb begin
        m_valid_nx = m_valid;
        m_data_nx  = m_data;
        s_valid_nx = s_valid;
        s_data_nx  = s_data;
        if (SKID) begin
            if (drain) begin
                if (s_valid) begin
                    m_data_nx  = s_data;
                    s_valid_nx = 1'b0;
                    s_data_nx  = BUBBLE_ZERO ? '0 : s_data;
                end else if (accept) begin
                    m_data_nx = in_data;
                end else begin
                    m_valid_nx = 1'b0;
                    m_data_nx  = BUBBLE_ZERO ? '0 : m_data;
                end
            end else if (accept) begin
                if (!m_valid) begin
                    m_valid_nx = 1'b1;
                    m_data_nx  = in_data;
                end else begin
                    s_valid_nx = 1'b1;
                    s_data_nx  = in_data;
                end
            end
        end else begin
            if (accept) begin
                m_valid_nx = 1'b1;
                m_data_nx  = in_data;
            end else if (drain) begin
                m_valid_nx = 1'b0;
                m_data_nx  = BUBBLE_ZERO ? '0 : m_data;
            end
        end
        // Flush kills held entries and any payload accepted this same cycle.
        if (flush) begin
            m_valid_nx = 1'b0;
            s_valid_nx = 1'b0;
            m_data_nx  = BUBBLE_ZERO ? '0 : m_data;
            s_data_nx  = BUBBLE_ZERO ? '0 : s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            count_q <= 2'd0;
        end else begin
            m_valid <= m_valid_nx;
            m_data  <= m_data_nx;
            s_valid <= s_valid_nx;
            s_data  <= s_data_nx;
            count_q <= {1'b0, m_valid_nx} + {1'b0, s_valid_nx};
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the generalised successor to the fixed-field EX/MEM latch. It carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake. It adds stall (backpressure), flush (bubble insertion) and an optional 2-entry skid buffer, so `in_ready` can be fully registered. It is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB); the payload is the concatenation of that boundary's fields.

Parameters:
- DATA_W, 165, payload width in bits. Default = Instr 32 + RT 32 + ALU 32 + EXT 32 + PC8 32 + WBA 5.
- SKID, 1, 1 = 2-entry skid buffer with `in_ready` driven only by flops. 0 = single register with combinational `in_ready`.
- BUBBLE_ZERO, 1, 1 = `out_data` is forced to 0 whenever `out_valid` drops (0 instruction = nop). 0 = `out_data` holds its last value.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, upstream stage presents a payload.
- in_ready, output, 1, this stage can accept a payload this cycle.
- in_data, input, DATA_W, upstream payload.
- flush, input, 1, kill every entry held in this stage (branch/exception).
- out_valid, output, 1, `out_data` holds a live payload.
- out_ready, input, 1, downstream accepts the payload (0 = stall).
- out_data, output, DATA_W, payload to the downstream stage.
- count, output, 2, number of live entries (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Transfers:
  - Accept = `in_valid & in_ready`.
  - Drain = `out_valid & out_ready`.
  - All state updates on the rising edge of `clk` only.
- Reset: synchronous. While `rst`=1 at an edge:
  - `out_valid`=0, `out_data`=0, skid entry invalid and zeroed, `count`=0.
  - `in_ready` is forced to 0 combinationally while `rst`=1.
  - From the first cycle after `rst` deasserts, `in_ready`=1.
  - Reset mid-transfer discards all entries. No accept occurs in a cycle where `rst`=1.
- SKID=1 storage: main register M (drives `out_*`) and skid register S.
  - `in_ready` = !S.valid, taken directly from the flop. No combinational path from `out_ready`.
  - Empty, accept: M <= `in_data` next edge; `out_valid`=1 after 1 cycle.
  - M valid, drain, no accept: M <= S if S is valid, else M becomes invalid.
  - M valid, drain and accept, S empty: M <= `in_data`.
  - M valid, no drain, accept: S <= `in_data`; `in_ready` = 0 the next cycle.
  - M and S valid, drain: M <= S, S empties, `in_ready` = 1 the next cycle.
  - Ordering is strictly FIFO. No payload is lost or duplicated. Throughput is 1 per cycle when `out_ready` is held high.
- SKID=0:
  - `in_ready` = !`out_valid` | `out_ready` (combinational).
  - Accept loads M. Drain without accept invalidates M.
- Stall: while `out_ready`=0, `out_data` and `out_valid` stay stable and the payload must not change.
- Flush: synchronous, one cycle.
  - Next edge: `out_valid`=0, S invalid, `count`=0.
  - A payload accepted in the same cycle as `flush` is discarded. Upstream observes the accept and the payload is killed.
  - A drain in the flush cycle still counts as a completed transfer downstream.
  - `rst` has priority over `flush`.
- BUBBLE_ZERO=1: every edge that leaves M invalid (drain to empty, flush) also writes `out_data`=0. Same rule applies to S data.
- `count` = M.valid + S.valid, registered, updated on the same edge as the entries.
- Simultaneous `in_valid` with `in_ready`=0: no state change. Upstream must hold `in_data`.

Test Plan:
- Reset, then `in_valid`=1 with `in_data`=0xA..A1, 0xA..A2, 0xA..A3 on consecutive cycles, `out_ready`=1 → `out_data` shows A1, A2, A3 on cycles 1, 2, 3; `count` stays 1; `in_ready` stays 1.
- Stall: feed P1 and P2 back-to-back with `out_ready`=0 (SKID=1) → `count`=2; `in_ready`=0 the cycle after P2; `out_data`=P1 held. Raise `out_ready` → P1 then P2 are emitted in order; `in_ready` returns to 1 one cycle after P1 drains.
- Flush with `count`=2 and a simultaneous accept of P3 → next cycle `out_valid`=0, `count`=0, `out_data`=0 (BUBBLE_ZERO=1); P3 never appears at the output.
- Reset mid-stall (`count`=2, `rst` pulsed for 1 cycle) → `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=0 during `rst`, then 1. Assert `rst` and `flush` together → reset result.
- SKID=0, DATA_W=8: `out_ready` toggling 1,0,1,0 with a continuous stream 0x01, 0x02, ... → `in_ready` mirrors `out_ready` while full; the output sequence is 0x01, 0x02, ... with no gaps lost and no duplicates.
- Random `in_valid`/`out_ready`/`flush` for 10k cycles (SKID=0 and 1) against a queue model → output order matches; `count` ≤ 2 (≤ 1 for SKID=0); no output change while stalled.
